// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous position controller for the bouncing sprite.
// The sprite's top-left corner moves by (speed+1) pixels per axis once every
// FRAME_DIV frames, or once per step request while paused. It clamps and reflects
// at the screen limits, and position changes land inside vertical blanking.
module sprite_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPRITE_W  = 100,
    parameter int SPRITE_H  = 100,
    parameter int X_INIT    = 430,
    parameter int Y_INIT    = 50,
    parameter int FRAME_DIV = 2
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       run,
    input  logic       step,
    input  logic [1:0] speed,
    input  logic       dir_set_valid,
    input  logic [1:0] dir_in,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic [1:0] dir,
    output logic       bounce,
    output logic [3:0] bounce_edge,
    output logic       busy
);

    // Position limits, in signed form for the candidate compare and unsigned for the clamp value.
    localparam logic signed [10:0] XMAX_S  = 11'(H_ACTIVE - SPRITE_W);
    localparam logic signed [10:0] YMAX_S  = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [9:0]         XMAX_U  = 10'(H_ACTIVE - SPRITE_W);
    localparam logic [9:0]         YMAX_U  = 10'(V_ACTIVE - SPRITE_H);
    localparam logic [7:0]         FC_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_CALC,
        S_COMMIT
    } state_t;

    state_t state, state_nx;

    logic              vsync_q;
    logic              tick;
    logic              wait_tick;
    logic              upd_tick;
    logic              take_manual;
    logic              move_req;
    logic [7:0]        frame_cnt;
    logic              step_pend;
    logic [1:0]        spd_q;
    logic signed [10:0] step_amt;
    logic signed [10:0] cur_x;
    logic signed [10:0] cur_y;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic              x_lo, x_hi, y_lo, y_hi;
    logic              x_hit, y_hit, any_hit;
    logic [9:0]        x_new, y_new;
    logic              dir_pend;
    logic [1:0]        dir_pend_val;

    // A tick is the first cycle vsync is seen low; ticks outside WAIT are ignored entirely.
    assign tick        = vsync_q & ~vsync;
    assign wait_tick   = tick && (state == S_WAIT);
    assign upd_tick    = (frame_cnt == FC_LAST);
    assign take_manual = wait_tick && step_pend && !run;
    assign move_req    = take_manual || (wait_tick && upd_tick && run);
    assign busy        = (state != S_WAIT);

    assign step_amt = signed'({9'd0, spd_q}) + 11'sd1;
    assign cur_x    = signed'({1'b0, logo_x});
    assign cur_y    = signed'({1'b0, logo_y});

    // Reflection: landing on or past a limit clamps to it; the overshoot is dropped.
    assign x_lo    = (nx <= 11'sd0);
    assign x_hi    = (nx >= XMAX_S);
    assign y_lo    = (ny <= 11'sd0);
    assign y_hi    = (ny >= YMAX_S);
    assign x_hit   = x_lo | x_hi;
    assign y_hit   = y_lo | y_hi;
    assign any_hit = x_hit | y_hit;
    assign x_new   = x_lo ? 10'd0 : (x_hi ? XMAX_U : nx[9:0]);
    assign y_new   = y_lo ? 10'd0 : (y_hi ? YMAX_U : ny[9:0]);

    // vsync history for tick detection; resets high so a low vsync at release is not a tick.
    // NOTE: every clocked block uses non-blocking assignments so all registers update together.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) vsync_q <= 1'b1;
        else      vsync_q <= vsync;
    end

    // Frame divider: counts accepted ticks and wraps on the update tick.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst)           frame_cnt <= 8'd0;
        else if (wait_tick) frame_cnt <= upd_tick ? 8'd0 : frame_cnt + 8'd1;
    end

    // Pending manual step: only meaningful while paused, consumed by the next tick.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst)             step_pend <= 1'b0;
        else if (run)         step_pend <= 1'b0;
        else if (step)        step_pend <= 1'b1;
        else if (take_manual) step_pend <= 1'b0;
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= S_WAIT;
        else      state <= state_nx;
    end

    // FSM next state: WAIT -> CALC on a move request, then CALC -> COMMIT -> WAIT.
    // NOTE: state_nx is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT:   if (move_req) state_nx = S_CALC;
            S_CALC:   state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_WAIT;
            default:  state_nx = S_WAIT;
        endcase
    end

    // Speed is captured with the move request so a mid-move change cannot affect it.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst)          spd_q <= 2'd0;
        else if (move_req) spd_q <= speed;
    end

    // Candidate position, computed with the direction in force during CALC.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            nx <= 11'sd0;
            ny <= 11'sd0;
        end else if (state == S_CALC) begin
            nx <= dir[1] ? cur_x - step_amt : cur_x + step_amt;
            ny <= dir[0] ? cur_y - step_amt : cur_y + step_amt;
        end
    end

    // Commit of position, bounce pulse and the sticky edge record.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            logo_x      <= 10'(X_INIT);
            logo_y      <= 10'(Y_INIT);
            bounce      <= 1'b0;
            bounce_edge <= 4'd0;
        end else begin
            bounce <= 1'b0;
            if (state == S_COMMIT) begin
                logo_x <= x_new;
                logo_y <= y_new;
                if (any_hit) begin
                    bounce      <= 1'b1;
                    bounce_edge <= {x_lo, x_hi, y_lo, y_hi};
                end
            end
        end
    end

    // Direction: immediate load in WAIT; during a move a forced value is held and
    // overrides the reflection flips at COMMIT.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            dir          <= 2'b01;
            dir_pend     <= 1'b0;
            dir_pend_val <= 2'b00;
        end else begin
            case (state)
                S_WAIT: begin
                    if (dir_set_valid) dir <= dir_in;
                end
                S_CALC: begin
                    if (dir_set_valid) begin
                        dir_pend     <= 1'b1;
                        dir_pend_val <= dir_in;
                    end
                end
                S_COMMIT: begin
                    if (dir_set_valid) dir <= dir_in;
                    else if (dir_pend) dir <= dir_pend_val;
                    else               dir <= dir ^ {x_hit, y_hit};
                    dir_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl. A behavioural model tracks the
// sprite as integers (position, direction, tick count, pending step) and every
// frame is compared cycle by cycle against the expected CALC/COMMIT timing.
module tb_sprite_motion_ctrl;

    localparam int FD   = 2;
    localparam int XMAX = 540;
    localparam int YMAX = 380;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       dir_set_valid = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic [9:0] logo_x, logo_y;
    logic [1:0] dir;
    logic       bounce;
    logic [3:0] bounce_edge;
    logic       busy;

    int         m_x, m_y, m_ticks;
    logic [1:0] m_dir;
    logic [3:0] m_edge;
    bit         m_pend;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 pclk = ~pclk;

    sprite_motion_ctrl #(
        .H_ACTIVE(640), .V_ACTIVE(480), .SPRITE_W(100), .SPRITE_H(100),
        .X_INIT(430), .Y_INIT(50), .FRAME_DIV(FD)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .run(run), .step(step),
        .speed(speed), .dir_set_valid(dir_set_valid), .dir_in(dir_in),
        .logo_x(logo_x), .logo_y(logo_y), .dir(dir), .bounce(bounce),
        .bounce_edge(bounce_edge), .busy(busy)
    );

    function automatic void model_reset();
        m_x = 430; m_y = 50; m_dir = 2'b01; m_edge = 4'd0; m_ticks = 0; m_pend = 1'b0;
    endfunction

    // One move of the sprite: step each axis, clamp at the walls, reverse on contact.
    function automatic bit model_move(int s);
        int cx, cy;
        logic [3:0] e;
        e  = 4'd0;
        cx = m_dir[1] ? m_x - s : m_x + s;
        cy = m_dir[0] ? m_y - s : m_y + s;
        if (cx <= 0) begin cx = 0; e[3] = 1'b1; end
        else if (cx >= XMAX) begin cx = XMAX; e[2] = 1'b1; end
        if (cy <= 0) begin cy = 0; e[1] = 1'b1; end
        else if (cy >= YMAX) begin cy = YMAX; e[0] = 1'b1; end
        m_x = cx;
        m_y = cy;
        m_dir = m_dir ^ {e[3] | e[2], e[1] | e[0]};
        if (e != 4'd0) m_edge = e;
        return e != 4'd0;
    endfunction

    task automatic set_run(input bit r);
        @(negedge pclk);
        run = r;
        if (r) m_pend = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge pclk);
        step = 1'b1;
        @(negedge pclk);
        step = 1'b0;
        if (!run) m_pend = 1'b1;
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge pclk);
        dir_set_valid = 1'b1;
        dir_in = d;
        @(negedge pclk);
        dir_set_valid = 1'b0;
        m_dir = d;
        n_checks++;
        if (dir !== d) begin n_errors++; $display("FAIL set_dir: dir got %b expected %b", dir, d); end
    endtask

    // One vsync frame; optionally forces a direction in the cycle after the tick.
    task automatic frame(input bit mid_en, input logic [1:0] mid_dir);
        bit mv, hit;
        int old_x, old_y, nb;
        old_x = m_x; old_y = m_y; nb = 0; hit = 1'b0;
        @(negedge pclk);
        vsync = 1'b0;
        m_ticks++;
        mv = (run && (m_ticks % FD == 0)) || (!run && m_pend);
        if (!run) m_pend = 1'b0;
        if (mv) hit = model_move(int'(speed) + 1);
        if (mid_en) m_dir = mid_dir;
        for (int i = 1; i <= 8; i++) begin
            @(negedge pclk);
            nb += int'(bounce);
            if (i == 1 || i == 2) begin
                n_checks++;
                if (busy !== mv) begin n_errors++; $display("FAIL busy_t%0d: got %b expected %b", i, busy, mv); end
            end
            if (i == 2) begin
                n_checks++;
                if (logo_x !== 10'(old_x) || logo_y !== 10'(old_y)) begin
                    n_errors++; $display("FAIL early_pos: got (%0d,%0d) expected (%0d,%0d)", logo_x, logo_y, old_x, old_y);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (logo_x !== 10'(m_x) || logo_y !== 10'(m_y)) begin
                    n_errors++; $display("FAIL pos: got (%0d,%0d) expected (%0d,%0d)", logo_x, logo_y, m_x, m_y);
                end
                n_checks++;
                if (dir !== m_dir) begin n_errors++; $display("FAIL dir: got %b expected %b", dir, m_dir); end
                n_checks++;
                if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_t3: got %b expected 0", busy); end
                n_checks++;
                if (bounce !== hit) begin n_errors++; $display("FAIL bounce_t3: got %b expected %b", bounce, hit); end
            end
            if (i == 1 && mid_en) begin dir_set_valid = 1'b1; dir_in = mid_dir; end
            if (i == 2) dir_set_valid = 1'b0;
        end
        vsync = 1'b1;
        repeat (4) @(negedge pclk);
        n_checks++;
        if (nb !== int'(hit)) begin n_errors++; $display("FAIL bounce_count: got %0d expected %0d", nb, hit); end
        n_checks++;
        if (bounce_edge !== m_edge) begin n_errors++; $display("FAIL bounce_edge: got %b expected %b", bounce_edge, m_edge); end
    endtask

    task automatic test_reset();
        model_reset();
        #3 rst = 1'b0;
        #14;
        n_checks++;
        if (logo_x !== 10'd430 || logo_y !== 10'd50) begin n_errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (430,50)", logo_x, logo_y); end
        n_checks++;
        if (dir !== 2'b01 || bounce !== 1'b0 || bounce_edge !== 4'd0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: dir %b bounce %b edge %b busy %b expected 01 0 0000 0", dir, bounce, bounce_edge, busy);
        end
        @(negedge pclk);
        rst = 1'b1;
    endtask

    task automatic test_auto_motion();
        set_run(1'b1);
        speed = 2'd0;
        frame(1'b0, 2'b00);
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd431 || logo_y !== 10'd49) begin n_errors++; $display("FAIL auto_1: got (%0d,%0d) expected (431,49)", logo_x, logo_y); end
        frame(1'b0, 2'b00);
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd432 || logo_y !== 10'd48 || dir !== 2'b01) begin
            n_errors++; $display("FAIL auto_2: got (%0d,%0d) dir %b expected (432,48) dir 01", logo_x, logo_y, dir);
        end
    endtask

    task automatic test_latency();
        set_run(1'b0);
        speed = 2'd0;
        pulse_step();
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd433 || logo_y !== 10'd47) begin n_errors++; $display("FAIL latency_pos: got (%0d,%0d) expected (433,47)", logo_x, logo_y); end
    endtask

    task automatic test_right_edge();
        set_dir(2'b00);
        speed = 2'd3;
        repeat (26) begin pulse_step(); frame(1'b0, 2'b00); end
        speed = 2'd0;
        pulse_step();
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd538 || dir !== 2'b00) begin n_errors++; $display("FAIL pre_edge: got x %0d dir %b expected 538 00", logo_x, dir); end
        speed = 2'd3;
        pulse_step();
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd540 || dir !== 2'b10 || bounce_edge !== 4'b0100) begin
            n_errors++; $display("FAIL right_edge: got x %0d dir %b edge %b expected 540 10 0100", logo_x, dir, bounce_edge);
        end
    endtask

    task automatic test_two_steps();
        pulse_step();
        pulse_step();
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd536 || logo_y !== 10'd160) begin n_errors++; $display("FAIL two_steps_1: got (%0d,%0d) expected (536,160)", logo_x, logo_y); end
        frame(1'b0, 2'b00);
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd536 || logo_y !== 10'd160) begin n_errors++; $display("FAIL two_steps_3: got (%0d,%0d) expected (536,160)", logo_x, logo_y); end
    endtask

    task automatic test_dir_override();
        repeat (54) begin pulse_step(); frame(1'b0, 2'b00); end
        pulse_step();
        frame(1'b1, 2'b10);
        n_checks++;
        if (logo_x !== 10'd316 || logo_y !== 10'd380 || dir !== 2'b10 || bounce_edge !== 4'b0001) begin
            n_errors++; $display("FAIL dir_override: got (%0d,%0d) dir %b edge %b expected (316,380) 10 0001", logo_x, logo_y, dir, bounce_edge);
        end
    endtask

    task automatic test_corner();
        set_dir(2'b11);
        speed = 2'd3;
        for (int i = 0; i < 100 && m_x > 0; i++) begin pulse_step(); frame(1'b0, 2'b00); end
        for (int i = 0; i < 100 && m_y > 0; i++) begin set_dir(2'b11); pulse_step(); frame(1'b0, 2'b00); end
        set_dir(2'b00);
        speed = 2'd0;
        pulse_step();
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd1 || logo_y !== 10'd1) begin n_errors++; $display("FAIL corner_setup: got (%0d,%0d) expected (1,1)", logo_x, logo_y); end
        set_dir(2'b11);
        speed = 2'd1;
        pulse_step();
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd0 || logo_y !== 10'd0 || dir !== 2'b00 || bounce_edge !== 4'b1010) begin
            n_errors++; $display("FAIL corner: got (%0d,%0d) dir %b edge %b expected (0,0) 00 1010", logo_x, logo_y, dir, bounce_edge);
        end
    endtask

    task automatic test_reset_mid();
        set_run(1'b0);
        speed = 2'd2;
        pulse_step();
        @(negedge pclk);
        vsync = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_calc: busy got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (logo_x !== 10'd430 || logo_y !== 10'd50 || dir !== 2'b01 || busy !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: got (%0d,%0d) dir %b busy %b expected (430,50) 01 0", logo_x, logo_y, dir, busy);
        end
        vsync = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        model_reset();
        speed = 2'd0;
        frame(1'b0, 2'b00);
        set_run(1'b1);
        frame(1'b0, 2'b00);
        n_checks++;
        if (logo_x !== 10'd431 || logo_y !== 10'd49) begin n_errors++; $display("FAIL post_reset: got (%0d,%0d) expected (431,49)", logo_x, logo_y); end
    endtask

    task automatic test_random();
        logic [1:0] d;
        logic [1:0] md;
        bit mid;
        for (int i = 0; i < 80; i++) begin
            set_run(1'($urandom_range(0, 1)));
            speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) pulse_step();
            if ($urandom_range(0, 3) == 0) begin d = 2'($urandom_range(0, 3)); set_dir(d); end
            mid = ($urandom_range(0, 3) == 0);
            md = 2'($urandom_range(0, 3));
            frame(mid, md);
        end
    endtask

    initial begin
        test_reset();
        test_auto_motion();
        test_latency();
        test_right_edge();
        test_two_steps();
        test_dir_override();
        test_corner();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
